sclkfifolut_wrarb: RTL and testbench

Round-robin write arbiter that shares one `sclkfifolut` write port between `NUM_REQ` requesters. Each requester uses a valid/ready handshake. The arbiter grants one owner at a time, for a burst of up to `MAX_BURST` words. Writes to the FIFO are registered. Space accounting uses `fifo_level` plus the in-flight write, so the FIFO never sees a write while full and no word is ever dropped.

---
 rtl/sclkfifolut_wrarb.sv | 147 ++++++++++++++
 tb/tb_sclkfifolut_wrarb.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sclkfifolut_wrarb.sv
// Round-robin write arbiter sharing one sclkfifolut write port between NUM_REQ requesters.
// Optional statistics counters are enabled with SCLKFIFOLUT_WRARB_STATS_EN.
module sclkfifolut_wrarb #(
  parameter int unsigned NUM_REQ         = 4,
  parameter int unsigned FIFO_WIDTH      = 32,
  parameter int unsigned LOG2_FIFO_DEPTH = 3,
  parameter int unsigned MAX_BURST       = 4
) (
  input  logic                            clk,
  input  logic                            srst,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*FIFO_WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic                            fifo_wen,
  output logic [FIFO_WIDTH-1:0]           fifo_wdata,
  input  logic [LOG2_FIFO_DEPTH:0]        fifo_level,
  input  logic                            fifo_wfull
`ifdef SCLKFIFOLUT_WRARB_STATS_EN
  ,
  output logic [31:0]                     stat_words,
  output logic [31:0]                     stat_stall
`endif
);

  localparam int unsigned IW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CW    = $clog2(MAX_BURST + 1);
  localparam int unsigned LW    = LOG2_FIFO_DEPTH + 2;
  localparam int unsigned DEPTH = 1 << LOG2_FIFO_DEPTH;

  typedef enum logic {S_IDLE, S_GRANT} state_e;

  state_e                  state_q;
  logic [IW-1:0]           owner_q;
  logic [IW-1:0]           last_q;
  logic [CW-1:0]           cnt_q;
  logic                    fifo_wen_q;
  logic [FIFO_WIDTH-1:0]   fifo_wdata_q;

  logic [FIFO_WIDTH-1:0]   req_words [NUM_REQ];
  logic [IW-1:0]           pick;
  int unsigned             idx;
  logic                    any_valid;
  logic                    in_grant;
  logic                    owner_valid;
  logic                    space_ok;
  logic                    xfer;
  logic [LW-1:0]           used;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_words
    assign req_words[g] = req_data[g*FIFO_WIDTH +: FIFO_WIDTH];
  end

  // Occupancy including the write already on its way to the FIFO
  always_comb begin
    used     = LW'(fifo_level) + LW'(fifo_wen_q);
    space_ok = used < LW'(DEPTH);
  end

  // First valid requester after the previous owner, with wrap
  always_comb begin
    pick      = last_q;
    any_valid = 1'b0;
    idx       = 0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = (32'(last_q) + k) % NUM_REQ;
      if (!any_valid && req_valid[IW'(idx)]) begin
        any_valid = 1'b1;
        pick      = IW'(idx);
      end
    end
  end

  always_comb begin
    in_grant    = (state_q == S_GRANT);
    owner_valid = req_valid[owner_q];
    xfer        = in_grant && owner_valid && space_ok;
    req_ready   = '0;
    req_ready[owner_q] = in_grant && space_ok;
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state_q      <= S_IDLE;
      owner_q      <= '0;
      last_q       <= IW'(NUM_REQ - 1);
      cnt_q        <= '0;
      fifo_wen_q   <= 1'b0;
      fifo_wdata_q <= '0;
    end else begin
      fifo_wen_q <= xfer;
      if (xfer) fifo_wdata_q <= req_words[owner_q];
      case (state_q)
        S_IDLE: begin
          if (any_valid) begin
            owner_q <= pick;
            cnt_q   <= '0;
            state_q <= S_GRANT;
          end
        end
        S_GRANT: begin
          if (!owner_valid) begin
            last_q  <= owner_q;
            state_q <= S_IDLE;
          end else if (xfer) begin
            if (cnt_q == CW'(MAX_BURST - 1)) begin
              last_q  <= owner_q;
              cnt_q   <= '0;
              state_q <= S_IDLE;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign fifo_wen   = fifo_wen_q;
  assign fifo_wdata = fifo_wdata_q;

`ifdef SCLKFIFOLUT_WRARB_STATS_EN
  logic [31:0] stat_words_q, stat_words_d;
  logic [31:0] stat_stall_q, stat_stall_d;

  always_comb begin
    stat_words_d = stat_words_q + (xfer ? 32'd1 : 32'd0);
    stat_stall_d = stat_stall_q + ((in_grant && owner_valid && !space_ok) ? 32'd1 : 32'd0);
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      stat_words_q <= '0;
      stat_stall_q <= '0;
    end else begin
      stat_words_q <= stat_words_d;
      stat_stall_q <= stat_stall_d;
    end
  end

  assign stat_words = stat_words_q;
  assign stat_stall = stat_stall_q;
`endif

  a_no_write_when_full: assert property (@(posedge clk) disable iff (srst) !(fifo_wen_q && fifo_wfull));

endmodule

// File: tb/tb_sclkfifolut_wrarb.sv
// Randomised and directed bench for sclkfifolut_wrarb with a behavioural FIFO and arbitration model.
// Stats checks compile in when SCLKFIFOLUT_WRARB_STATS_EN is defined.
module tb_sclkfifolut_wrarb;
  localparam int NREQ  = 4;
  localparam int W     = 32;
  localparam int DEPTH = 8;
  localparam int MAXB  = 4;

  logic             clk = 1'b0;
  logic             srst = 1'b1;
  logic [NREQ-1:0]  req_valid = '0;
  logic [NREQ*W-1:0] req_data;
  logic [NREQ-1:0]  req_ready;
  logic             fifo_wen;
  logic [W-1:0]     fifo_wdata;
  logic [3:0]       fifo_level;
  logic             fifo_wfull;
  logic             fifo_ren = 1'b0;
`ifdef SCLKFIFOLUT_WRARB_STATS_EN
  logic [31:0]      stat_words, stat_stall;
`endif

  logic [W-1:0]     drv_data [NREQ];
  logic [W-1:0]     pq [NREQ][$];
  logic [W-1:0]     wlog [$];
  int               wcyc [$];
  int               lvl = 0;
  int               cyc = 0;
  int unsigned      vpct = 100;
  int unsigned      rpct = 0;
  int               checks = 0;
  int               failures = 0;

  // Reference model state
  int               m_owner = -1;
  int               m_last = NREQ - 1;
  int               m_cnt = 0;
  logic [31:0]      m_words = '0;
  logic [31:0]      m_stall = '0;
  logic [NREQ-1:0]  exp_ready = '0;
  logic             exp_wen = 1'b0;
  logic [W-1:0]     exp_wdata = '0;

  sclkfifolut_wrarb #(.NUM_REQ(NREQ), .FIFO_WIDTH(W), .LOG2_FIFO_DEPTH(3), .MAX_BURST(MAXB)) dut (
    .clk(clk), .srst(srst), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .fifo_wen(fifo_wen), .fifo_wdata(fifo_wdata), .fifo_level(fifo_level), .fifo_wfull(fifo_wfull)
`ifdef SCLKFIFOLUT_WRARB_STATS_EN
    , .stat_words(stat_words), .stat_stall(stat_stall)
`endif
  );

  always #5 clk = ~clk;

  always_comb begin
    req_data = '0;
    for (int i = 0; i < NREQ; i++) req_data[i*W +: W] = drv_data[i];
  end

  // Behavioural FIFO occupancy
  always @(posedge clk) begin
    if (srst) lvl <= 0;
    else lvl <= lvl + ((fifo_wen && lvl < DEPTH) ? 1 : 0) - ((fifo_ren && lvl > 0) ? 1 : 0);
  end
  assign fifo_level = 4'(lvl);
  assign fifo_wfull = (lvl == DEPTH);

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic drive_inputs();
    for (int i = 0; i < NREQ; i++) begin
      if (!req_valid[i] && pq[i].size() > 0 && $urandom_range(99) < vpct) begin
        req_valid[i] = 1'b1;
        drv_data[i]  = pq[i][0];
      end
    end
    fifo_ren  = ($urandom_range(99) < rpct);
    exp_ready = '0;
    if (m_owner >= 0 && (DEPTH - lvl - int'(exp_wen)) > 0) exp_ready[m_owner] = 1'b1;
  endtask

  // Advance the model by the rules for one cycle, clock the DUT, then respond as requesters
  task automatic tick();
    logic [NREQ-1:0] acc;
    logic            rst_now;
    logic            nxt_wen;
    logic [W-1:0]    nxt_wdata;
    int              free;
    bit              found;
    acc       = req_valid & req_ready;
    rst_now   = srst;
    free      = DEPTH - lvl - int'(exp_wen);
    nxt_wen   = 1'b0;
    nxt_wdata = exp_wdata;
    if (rst_now) begin
      m_owner = -1; m_last = NREQ - 1; m_cnt = 0; nxt_wdata = '0; m_words = '0; m_stall = '0;
    end else if (m_owner < 0) begin
      found = 0;
      for (int k = 1; k <= NREQ; k++) begin
        int p = (m_last + k) % NREQ;
        if (!found && req_valid[p]) begin found = 1; m_owner = p; m_cnt = 0; end
      end
    end else if (!req_valid[m_owner]) begin
      m_last = m_owner; m_owner = -1;
    end else if (free <= 0) begin
      m_stall = m_stall + 1;
    end else begin
      nxt_wen = 1'b1; nxt_wdata = drv_data[m_owner]; m_words = m_words + 1; m_cnt++;
      if (m_cnt == MAXB) begin m_last = m_owner; m_owner = -1; end
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
    exp_wen   = nxt_wen;
    exp_wdata = nxt_wdata;
    if (fifo_wen) begin wlog.push_back(fifo_wdata); wcyc.push_back(cyc); end
    if (!rst_now) begin
      for (int i = 0; i < NREQ; i++) begin
        if (acc[i]) begin void'(pq[i].pop_front()); req_valid[i] = 1'b0; end
      end
    end
    drive_inputs();
  endtask

  task automatic do_reset();
    srst = 1'b1;
    for (int i = 0; i < NREQ; i++) begin pq[i].delete(); req_valid[i] = 1'b0; drv_data[i] = '0; end
    vpct = 100; rpct = 0;
    tick();
    srst = 1'b0;
    wlog.delete(); wcyc.delete();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (req_ready !== 4'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0000", req_ready); end
    checks++; if (fifo_wen !== 1'b0) begin failures++; $display("FAIL reset_wen got=%b exp=0", fifo_wen); end
    checks++; if (fifo_wdata !== 32'h0) begin failures++; $display("FAIL reset_wdata got=%h exp=0", fifo_wdata); end
`ifdef SCLKFIFOLUT_WRARB_STATS_EN
    checks++; if (stat_words !== 32'h0) begin failures++; $display("FAIL reset_stat_words got=%0d exp=0", stat_words); end
    checks++; if (stat_stall !== 32'h0) begin failures++; $display("FAIL reset_stat_stall got=%0d exp=0", stat_stall); end
`endif
    tick();
    checks++; if (req_ready !== 4'b0) begin failures++; $display("FAIL idle_ready got=%b exp=0000", req_ready); end
  endtask

  task automatic test_single();
    do_reset();
    for (int k = 1; k <= 6; k++) pq[2].push_back(32'(k));
    drive_inputs();
    for (int c = 0; c < 30; c++) tick();
    checks++; if (wlog.size() != 6) begin failures++; $display("FAIL single_count got=%0d exp=6", wlog.size()); end
    for (int j = 0; j < 6 && j < wlog.size(); j++) begin
      checks++; if (wlog[j] !== 32'(j + 1)) begin failures++; $display("FAIL single_word%0d got=%0d exp=%0d", j, wlog[j], j + 1); end
    end
    if (wcyc.size() >= 6) begin
      checks++; if (wcyc[3] - wcyc[0] != 3) begin failures++; $display("FAIL single_burst_span got=%0d exp=3", wcyc[3] - wcyc[0]); end
      checks++; if (wcyc[4] - wcyc[3] != 2) begin failures++; $display("FAIL single_bubble got=%0d exp=2", wcyc[4] - wcyc[3]); end
      checks++; if (wcyc[5] - wcyc[4] != 1) begin failures++; $display("FAIL single_after_bubble got=%0d exp=1", wcyc[5] - wcyc[4]); end
    end
    checks++; if (fifo_level !== 4'd6) begin failures++; $display("FAIL single_level got=%0d exp=6", fifo_level); end
  endtask

  task automatic test_round_robin();
    do_reset();
    rpct = 100;
    for (int i = 0; i < NREQ; i++) for (int k = 0; k < 8; k++) pq[i].push_back(32'(i * 16 + k));
    drive_inputs();
    for (int c = 0; c < 50; c++) tick();
    checks++; if (wlog.size() != 32) begin failures++; $display("FAIL rr_count got=%0d exp=32", wlog.size()); end
    for (int j = 0; j < 32 && j < wlog.size(); j++) begin
      int b = j / 4;
      logic [W-1:0] e;
      e = 32'((b % 4) * 16 + (b / 4) * 4 + j % 4);
      checks++; if (wlog[j] !== e) begin failures++; $display("FAIL rr_word%0d got=%0d exp=%0d", j, wlog[j], e); end
    end
    if (wcyc.size() >= 20) begin
      checks++; if (wcyc[19] - wcyc[0] != 23) begin failures++; $display("FAIL rr_span got=%0d exp=23", wcyc[19] - wcyc[0]); end
    end
  endtask

  task automatic test_overflow();
    int held = 0;
    do_reset();
    for (int k = 0; k < 10; k++) pq[0].push_back(32'(100 + k));
    drive_inputs();
    for (int c = 0; c < 40; c++) begin
      checks++; if (fifo_wen && fifo_wfull) begin failures++; $display("FAIL ovf_write_full cyc=%0d got=1 exp=0", cyc); end
      if (req_valid[0] && fifo_level == 4'd8 && !req_ready[0]) held++;
      tick();
    end
    checks++; if (wlog.size() != 8) begin failures++; $display("FAIL ovf_count got=%0d exp=8", wlog.size()); end
    checks++; if (req_ready[0] !== 1'b0) begin failures++; $display("FAIL ovf_ready got=%b exp=0", req_ready[0]); end
    checks++; if (fifo_level !== 4'd8) begin failures++; $display("FAIL ovf_level got=%0d exp=8", fifo_level); end
`ifdef SCLKFIFOLUT_WRARB_STATS_EN
    checks++; if (stat_words !== 32'd8) begin failures++; $display("FAIL ovf_stat_words got=%0d exp=8", stat_words); end
    checks++; if (stat_stall !== 32'(held)) begin failures++; $display("FAIL ovf_stat_stall got=%0d exp=%0d", stat_stall, held); end
    checks++; if (stat_stall !== m_stall) begin failures++; $display("FAIL ovf_stat_stall_model got=%0d exp=%0d", stat_stall, m_stall); end
`endif
    fifo_ren = 1'b1;
    tick();
    for (int c = 0; c < 6; c++) tick();
    checks++; if (wlog.size() != 9) begin failures++; $display("FAIL ovf_resume_count got=%0d exp=9", wlog.size()); end
    if (wlog.size() >= 9) begin
      checks++; if (wlog[8] !== 32'd108) begin failures++; $display("FAIL ovf_ninth got=%0d exp=108", wlog[8]); end
    end
  endtask

  task automatic test_drop_valid();
    do_reset();
    pq[0].push_back(32'd200); pq[0].push_back(32'd201);
    pq[1].push_back(32'd300); pq[1].push_back(32'd301); pq[1].push_back(32'd302);
    drive_inputs();
    for (int c = 0; c < 20; c++) tick();
    checks++; if (wlog.size() != 5) begin failures++; $display("FAIL drop_count got=%0d exp=5", wlog.size()); end
    if (wlog.size() >= 5) begin
      checks++; if (wlog[1] !== 32'd201) begin failures++; $display("FAIL drop_w1 got=%0d exp=201", wlog[1]); end
      checks++; if (wlog[2] !== 32'd300) begin failures++; $display("FAIL drop_w2 got=%0d exp=300", wlog[2]); end
      checks++; if (wcyc[2] - wcyc[1] != 3) begin failures++; $display("FAIL drop_gap got=%0d exp=3", wcyc[2] - wcyc[1]); end
    end
    pq[0].push_back(32'd210); pq[2].push_back(32'd220);
    drive_inputs();
    for (int c = 0; c < 20; c++) tick();
    checks++; if (wlog.size() != 7) begin failures++; $display("FAIL drop_next_count got=%0d exp=7", wlog.size()); end
    if (wlog.size() >= 7) begin
      checks++; if (wlog[5] !== 32'd220) begin failures++; $display("FAIL drop_rr_first got=%0d exp=220", wlog[5]); end
      checks++; if (wlog[6] !== 32'd210) begin failures++; $display("FAIL drop_rr_second got=%0d exp=210", wlog[6]); end
    end
  endtask

  task automatic test_srst_mid_burst();
    int sz;
    logic [W-1:0] head3;
    do_reset();
    for (int k = 0; k < 6; k++) pq[3].push_back(32'(400 + k));
    drive_inputs();
    for (int c = 0; c < 20 && wlog.size() < 2; c++) tick();
    checks++; if (req_ready[3] !== 1'b1) begin failures++; $display("FAIL srst_pre_ready got=%b exp=1", req_ready[3]); end
    srst = 1'b1;
    tick();
    srst = 1'b0;
    checks++; if (req_ready !== 4'b0) begin failures++; $display("FAIL srst_ready got=%b exp=0000", req_ready); end
    checks++; if (fifo_wen !== 1'b0) begin failures++; $display("FAIL srst_wen got=%b exp=0", fifo_wen); end
    checks++; if (fifo_wdata !== 32'h0) begin failures++; $display("FAIL srst_wdata got=%h exp=0", fifo_wdata); end
    sz = wlog.size();
    head3 = pq[3][0];
    pq[0].push_back(32'd500); pq[0].push_back(32'd501);
    drive_inputs();
    for (int c = 0; c < 20; c++) tick();
    checks++; if (wlog.size() < sz + 3) begin failures++; $display("FAIL srst_after_count got=%0d exp>=%0d", wlog.size(), sz + 3); end
    else begin
      checks++; if (wlog[sz] !== 32'd500) begin failures++; $display("FAIL srst_port0_first got=%0d exp=500", wlog[sz]); end
      checks++; if (wlog[sz+1] !== 32'd501) begin failures++; $display("FAIL srst_port0_second got=%0d exp=501", wlog[sz+1]); end
      checks++; if (wlog[sz+2] !== head3) begin failures++; $display("FAIL srst_port3_resume got=%0d exp=%0d", wlog[sz+2], head3); end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] expq [NREQ][$];
    int total = 0;
    int pend;
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      int n = int'($urandom_range(40, 10));
      for (int k = 0; k < n; k++) begin
        pq[i].push_back(32'((i << 24) | k));
        expq[i].push_back(32'((i << 24) | k));
      end
      total += n;
    end
    drive_inputs();
    for (int c = 0; c < 1500; c++) begin
      if (c % 200 == 0) begin vpct = $urandom_range(100, 30); rpct = $urandom_range(90, 10); end
      checks++; if (req_ready !== exp_ready) begin failures++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", cyc, req_ready, exp_ready); end
      checks++; if (fifo_wen !== exp_wen) begin failures++; $display("FAIL rnd_wen cyc=%0d got=%b exp=%b", cyc, fifo_wen, exp_wen); end
      checks++; if (fifo_wdata !== exp_wdata) begin failures++; $display("FAIL rnd_wdata cyc=%0d got=%h exp=%h", cyc, fifo_wdata, exp_wdata); end
      checks++; if (fifo_wen && fifo_wfull) begin failures++; $display("FAIL rnd_write_full cyc=%0d got=1 exp=0", cyc); end
      tick();
    end
    vpct = 100; rpct = 100;
    for (int c = 0; c < 2000; c++) begin
      pend = 0;
      for (int i = 0; i < NREQ; i++) pend += pq[i].size();
      if (pend == 0) break;
      tick();
    end
    for (int c = 0; c < 10; c++) tick();
    checks++; if (wlog.size() != total) begin failures++; $display("FAIL rnd_total got=%0d exp=%0d", wlog.size(), total); end
    foreach (wlog[j]) begin
      int p = int'(wlog[j] >> 24);
      if (p < NREQ && expq[p].size() > 0) begin
        checks++; if (wlog[j] !== expq[p][0]) begin failures++; $display("FAIL rnd_order idx=%0d got=%h exp=%h", j, wlog[j], expq[p][0]); end
        void'(expq[p].pop_front());
      end else begin
        checks++; failures++; $display("FAIL rnd_unexpected idx=%0d got=%h exp=none", j, wlog[j]);
      end
    end
`ifdef SCLKFIFOLUT_WRARB_STATS_EN
    checks++; if (stat_words !== m_words) begin failures++; $display("FAIL rnd_stat_words got=%0d exp=%0d", stat_words, m_words); end
    checks++; if (stat_stall !== m_stall) begin failures++; $display("FAIL rnd_stat_stall got=%0d exp=%0d", stat_stall, m_stall); end
`endif
  endtask

  initial begin
    for (int i = 0; i < NREQ; i++) drv_data[i] = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_overflow();
    test_drop_valid();
    test_srst_mid_burst();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
